uart_msg_sender: RTL and testbench

Parametrised message transmitter feeding the `uart` TX port (`dataInTxValid`/`dataInTxBusy` handshake). It streams a fixed-length byte message, optionally terminated with CR/LF. It supports one-shot and repeat modes, a programmable inter-byte gap, and clean abort. It sits between firmware-free bring-up logic (key/button triggers) and the UART, and replaces hand-written per-design string sequencers.

---
 rtl/uart_pkg.sv | 15 +
 rtl/msg_byte_mux.sv | 28 ++
 rtl/uart_msg_sender.sv | 128 ++++++++++++
 tb/tb_uart_msg_sender.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART message sender.
package uart_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    GAP
  } state_t;

endpackage

// File: rtl/msg_byte_mux.sv
// Selects the outgoing byte: a message byte by index, or CR/LF past the
// end of the message.
module msg_byte_mux
  import uart_pkg::*;
#(
  parameter int MSG_LEN = 14,
  parameter int IDX_W   = $clog2(MSG_LEN + 2)
) (
  input  logic [MSG_LEN*8-1:0] msg,
  input  logic [IDX_W-1:0]     byteIdx,
  output logic [7:0]           byteOut
);

  always_comb begin
    byteOut = 8'h00;
    if (byteIdx == IDX_W'(MSG_LEN)) begin
      byteOut = CHAR_CR;
    end else if (byteIdx == IDX_W'(MSG_LEN + 1)) begin
      byteOut = CHAR_LF;
    end
    for (int i = 0; i < MSG_LEN; i++) begin
      if (byteIdx == IDX_W'(i)) begin
        byteOut = msg[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/uart_msg_sender.sv
// Streams a fixed message (optionally CR/LF terminated) into a UART TX port
// using the valid/busy handshake, with repeat, inter-byte gap and abort.
module uart_msg_sender
  import uart_pkg::*;
#(
  parameter int MSG_LEN     = 14,
  parameter int GAP_CYCLES  = 0,
  parameter int APPEND_CRLF = 0,
  parameter int IDX_W       = $clog2(MSG_LEN + 2)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 repeat_en,
  input  logic                 stop,
  input  logic [MSG_LEN*8-1:0] msg,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_busy,
  output logic                 active,
  output logic                 done,
  output logic [IDX_W-1:0]     byte_idx
);

  localparam int N = MSG_LEN + 2 * APPEND_CRLF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state, nextState;
  logic [IDX_W-1:0] idx, nextIdx;
  logic             stopLatch;
  logic             stopReq;
  logic             lastByte;
  logic             gapLast;
  logic             boundary;

  assign stopReq  = stop | stopLatch;
  assign lastByte = (idx == LAST_IDX);

  generate
    if (GAP_CYCLES > 0) begin : genGap
      localparam int GW = $clog2(GAP_CYCLES + 1);
      localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
      logic [GW-1:0] gapCnt;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          gapCnt <= '0;
        end else if (state != GAP) begin
          gapCnt <= '0;
        end else begin
          gapCnt <= gapCnt + GW'(1);
        end
      end

      assign gapLast = (state == GAP) && (gapCnt == GAP_LAST);
    end else begin : genNoGap
      assign gapLast = 1'b0;
    end
  endgenerate

  // A byte is finished either when busy falls (no gap) or on the last gap clock.
  assign boundary = ((GAP_CYCLES == 0) && (state == WAIT_LO) && !tx_busy) || gapLast;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      idx       <= '0;
      stopLatch <= 1'b0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
      if (nextState == IDLE) begin
        stopLatch <= 1'b0;
      end else if (stop) begin
        stopLatch <= 1'b1;
      end
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = ISSUE;
          nextIdx   = '0;
        end
      end
      ISSUE:   if (!tx_busy) nextState = WAIT_HI;
      WAIT_HI: if (tx_busy)  nextState = WAIT_LO;
      WAIT_LO: if (!tx_busy && (GAP_CYCLES > 0)) nextState = GAP;
      GAP:     nextState = GAP;
      default: nextState = IDLE;
    endcase
    if (boundary) begin
      if (stopReq) begin
        nextState = IDLE;
      end else if (!lastByte) begin
        nextState = ISSUE;
        nextIdx   = idx + IDX_W'(1);
      end else if (repeat_en) begin
        nextState = ISSUE;
        nextIdx   = '0;
      end else begin
        nextState = IDLE;
      end
    end
  end

  always_comb begin
    tx_valid = (state == ISSUE) && !tx_busy;
    active   = (state != IDLE);
    done     = boundary && !stopReq && lastByte;
  end

  assign byte_idx = idx;

  msg_byte_mux #(
    .MSG_LEN(MSG_LEN),
    .IDX_W  (IDX_W)
  ) uMux (
    .msg    (msg),
    .byteIdx(idx),
    .byteOut(tx_data)
  );

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed-plus-random bench: a behavioural UART busy model and an expected
// byte stream built from the message contents and pass/abort rules.
module tb_uart_msg_sender;

  localparam int MSG_LEN     = 6;
  localparam int GAP_CYCLES  = 3;
  localparam int APPEND_CRLF = 1;
  localparam int N           = MSG_LEN + 2 * APPEND_CRLF;
  localparam int IDX_W       = $clog2(MSG_LEN + 2);

  logic                 clk = 1'b0;
  logic                 resetn, start, repeat_en, stop;
  logic [MSG_LEN*8-1:0] msg;
  logic [7:0]           tx_data;
  logic                 tx_valid, tx_busy, active, done;
  logic [IDX_W-1:0]     byte_idx;

  int total = 0;
  int bad   = 0;

  uart_msg_sender #(
    .MSG_LEN    (MSG_LEN),
    .GAP_CYCLES (GAP_CYCLES),
    .APPEND_CRLF(APPEND_CRLF),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .repeat_en(repeat_en),
    .stop     (stop),
    .msg      (msg),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_busy  (tx_busy),
    .active   (active),
    .done     (done),
    .byte_idx (byte_idx)
  );

  always #5 clk = ~clk;

  // UART stand-in: busy for a random 2..6 clocks after each load strobe.
  int   uartCnt   = 0;
  logic forceBusy = 1'b0;
  assign tx_busy = (uartCnt != 0) || forceBusy;

  always @(posedge clk) begin
    if (uartCnt > 0) uartCnt <= uartCnt - 1;
    else if (tx_valid) uartCnt <= int'($urandom_range(6, 2));
  end

  int         cyc = 0;
  logic       busyPrev = 1'b0;
  logic [7:0] rxBytes[$];
  int         idxAt[$];
  int         strobeCyc[$];
  int         doneCyc[$];
  int         fallCyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_valid) begin
      rxBytes.push_back(tx_data);
      idxAt.push_back(int'(byte_idx));
      strobeCyc.push_back(cyc);
    end
    if (done) doneCyc.push_back(cyc);
    if (busyPrev && !tx_busy) fallCyc.push_back(cyc);
    busyPrev = tx_busy;
  end

  logic [7:0] msgBytes[MSG_LEN];

  function automatic logic [7:0] expByte(int k);
    if (k < MSG_LEN) return msgBytes[k];
    if (k == MSG_LEN) return 8'h0D;
    return 8'h0A;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(logic s, logic p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic newMessage();
    for (int i = 0; i < MSG_LEN; i++) begin
      msgBytes[i]  = 8'($urandom);
      msg[8*i +: 8] = msgBytes[i];
    end
  endtask

  task automatic clearLog();
    rxBytes.delete();
    idxAt.delete();
    strobeCyc.delete();
    doneCyc.delete();
    fallCyc.delete();
  endtask

  task automatic waitIdle(string tag);
    int k = 0;
    while ((active || tx_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_idle"}, {31'd0, active}, 32'd0);
  endtask

  task automatic waitStrobe(int idxWanted, string tag);
    int k = 0;
    while (!(tx_valid && byte_idx == IDX_W'(idxWanted)) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_strobeSeen"}, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic checkBytes(string tag, int count);
    checkOutput({tag, "_count"}, rxBytes.size(), count);
    for (int k = 0; k < count; k++) begin
      checkOutput($sformatf("%s_byte%0d", tag, k),
                  (k < rxBytes.size()) ? {24'd0, rxBytes[k]} : 32'hffff_ffff,
                  {24'd0, expByte(k % N)});
    end
  endtask

  initial begin
    int k;
    int nDone;

    resetn    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    repeat_en = 1'b0;
    msg       = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_txValid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_byteIdx", {{(32-IDX_W){1'b0}}, byte_idx}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // One-shot pass with CR/LF and gap timing
    newMessage();
    clearLog();
    applyStimulus(1'b1, 1'b0);
    waitIdle("oneShot");
    checkBytes("oneShot", N);
    checkOutput("oneShot_doneCount", doneCyc.size(), 1);
    for (int i = 1; i < N; i++) begin
      checkOutput($sformatf("oneShot_gap%0d", i),
                  (i < strobeCyc.size() && i <= fallCyc.size()) ? strobeCyc[i] - fallCyc[i-1] : -1,
                  GAP_CYCLES + 1);
    end
    checkOutput("oneShot_doneTime",
                (doneCyc.size() > 0 && fallCyc.size() >= N) ? doneCyc[0] - fallCyc[N-1] : -1,
                GAP_CYCLES);

    // Repeat mode: three passes, then repeat_en dropped
    newMessage();
    clearLog();
    repeat_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    nDone = 0;
    k = 0;
    while (nDone < 2 && k < 5000) begin
      @(negedge clk);
      if (done) nDone++;
      k++;
    end
    checkOutput("repeat_twoDones", nDone, 2);
    @(negedge clk);
    repeat_en = 1'b0;
    waitIdle("repeat");
    checkBytes("repeat", 3 * N);
    checkOutput("repeat_doneCount", doneCyc.size(), 3);
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("repeat_restrobe%0d", p),
                  (p < doneCyc.size() && N*(p+1) < strobeCyc.size()) ? strobeCyc[N*(p+1)] - doneCyc[p] : -1,
                  1);
    end

    // Abort during byte 5, then restart from byte 0
    newMessage();
    clearLog();
    applyStimulus(1'b1, 1'b0);
    waitStrobe(5, "abort");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    waitIdle("abort");
    checkBytes("abort", 6);
    checkOutput("abort_doneCount", doneCyc.size(), 0);
    clearLog();
    applyStimulus(1'b1, 1'b0);
    waitIdle("restart");
    checkOutput("restart_firstIdx", (idxAt.size() > 0) ? idxAt[0] : -1, 0);
    checkBytes("restart", N);
    checkOutput("restart_doneCount", doneCyc.size(), 1);

    // start and stop together in IDLE: exactly one byte
    clearLog();
    applyStimulus(1'b1, 1'b1);
    waitIdle("startStop");
    checkBytes("startStop", 1);
    checkOutput("startStop_doneCount", doneCyc.size(), 0);

    // Busy held high at start: strobe lands in the cycle busy falls
    clearLog();
    @(posedge clk);
    #1 forceBusy = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    repeat (19) @(negedge clk);
    checkOutput("forceBusy_noStrobe", strobeCyc.size(), 0);
    checkOutput("forceBusy_active", {31'd0, active}, 32'd1);
    @(posedge clk);
    #1 forceBusy = 1'b0;
    waitIdle("forceBusy");
    checkOutput("forceBusy_strobeAtFall",
                (strobeCyc.size() > 0 && fallCyc.size() > 0) ? strobeCyc[0] - fallCyc[0] : -1, 0);
    checkBytes("forceBusy", N);

    // Reset while waiting for busy to fall on byte 1
    clearLog();
    applyStimulus(1'b1, 1'b0);
    waitStrobe(1, "midReset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    checkOutput("midReset_txValid", {31'd0, tx_valid}, 32'd0);
    checkOutput("midReset_active", {31'd0, active}, 32'd0);
    checkOutput("midReset_done", {31'd0, done}, 32'd0);
    checkOutput("midReset_byteIdx", {{(32-IDX_W){1'b0}}, byte_idx}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("midReset_startIgnored", {31'd0, active}, 32'd0);
    resetn = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    checkOutput("midReset_staysIdle", {31'd0, active}, 32'd0);
    waitIdle("midReset");
    checkOutput("midReset_strobeCount", strobeCyc.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
